// File: rtl/ifetch.sv
// ifetch: instruction fetch controller.
// Owns the program counter and reads instruction memory through a req/ack
// handshake. Each fetched word is presented on ir_d together with a
// one-cycle en_ir strobe, which drives the instruction register directly.
//
// Parameters:
//   AW      - program counter / memory address width
//   DW      - instruction width (matches the instruction register)
//   RST_PC  - program counter value after reset
//   TIMEOUT - max cycles mem_req waits for mem_ack (0 = wait forever)
//
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   fetch_go       - start a fetch (sampled in IDLE only)
//   pc_load        - load pc from pc_load_val (IDLE only)
//   pc_load_val    - branch/jump target
//   mem_req        - read request, high in REQ
//   mem_addr       - read address, always equal to pc
//   mem_ack        - memory response, mem_rdata valid while high
//   mem_rdata      - instruction word from memory
//   ir_d           - registered instruction word
//   en_ir          - one-cycle load strobe for the instruction register
//   pc             - address of the next instruction to fetch
//   busy           - high in REQ and LOAD
//   fetch_err      - one-cycle pulse after a timed-out fetch
module ifetch #(
  parameter int unsigned    AW      = 16,
  parameter int unsigned    DW      = 16,
  parameter logic [AW-1:0]  RST_PC  = '0,
  parameter int unsigned    TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_go,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_load_val,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir_d,
  output logic          en_ir,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          fetch_err
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_LOAD
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_pc,    w_pc_nxt;
  logic [DW-1:0] r_ir,    w_ir_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic          r_err,   w_err_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RST_PC;
      r_ir    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A simultaneous load and go fetches from the loaded address,
        // since REQ presents the updated r_pc.
        if (pc_load) w_pc_nxt = pc_load_val;
        if (fetch_go) begin
          w_state_nxt = S_REQ;
          w_cnt_nxt   = '0;
        end
      end
      S_REQ: begin
        // Ack takes priority over timeout on the final waiting edge.
        if (mem_ack) begin
          w_ir_nxt    = mem_rdata;
          w_state_nxt = S_LOAD;
        end else if ((TIMEOUT != 0) && (r_cnt == LAST)) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_LOAD: begin
        w_pc_nxt    = r_pc + AW'(1);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem_req   = (r_state == S_REQ);
  assign busy      = (r_state != S_IDLE);
  assign en_ir     = (r_state == S_LOAD);
  assign mem_addr  = r_pc;
  assign pc        = r_pc;
  assign ir_d      = r_ir;
  assign fetch_err = r_err;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch (RST_PC=16'h0010, TIMEOUT=15).
// A memory responder acks after a programmed number of request cycles; a
// scoreboard queue holds the {address, word} expected at each en_ir strobe.
module tb_ifetch;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_go = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ir_d;
  logic        en_ir;
  logic [15:0] pc;
  logic        busy;
  logic        fetch_err;

  ifetch #(.AW(16), .DW(16), .RST_PC(RST_PC), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .fetch_go(fetch_go), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_d(ir_d), .en_ir(en_ir),
    .pc(pc), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } sb_t;
  sb_t sb_q[$];

  // Responder configuration (lat = 0 means never ack).
  int unsigned lat = 0;
  logic [15:0] rd_word = '0;
  logic        xor_addr = 1'b0;
  logic        stray_ack = 1'b0;
  int unsigned req_cyc = 0;
  logic [15:0] first_addr = '0;

  // Monitor counters.
  int unsigned req_cnt = 0;
  int unsigned en_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned cyc = 0;
  int unsigned en_cyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory responder: ack during the lat-th cycle of a request.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      req_cyc = 0;
      mem_ack = 1'b0;
    end else if (mem_req) begin
      req_cyc++;
      if (req_cyc == 1) first_addr = mem_addr;
      mem_ack   = (lat != 0) && (req_cyc == lat);
      mem_rdata = xor_addr ? (rd_word ^ mem_addr) : rd_word;
    end else begin
      req_cyc = 0;
      mem_ack = stray_ack;
    end
  end

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    sb_t e;
    cyc++;
    if (mem_req) req_cnt++;
    if (fetch_err) err_cnt++;
    if (en_ir) begin
      en_cnt++;
      en_cyc_q.push_back(cyc);
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_en_ir actual=%h required=none", ir_d);
      end else begin
        e = sb_q.pop_front();
        if (ir_d !== e.data || mem_addr !== e.addr) begin
          failures++;
          $display("FAIL sb_load actual=%h@%h required=%h@%h", ir_d, mem_addr, e.data, e.addr);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_timeout actual=busy required=idle", name);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] val;
    int unsigned lat;
    logic [15:0] data;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
    int unsigned exp_req;
    int unsigned exp_en;
    int unsigned exp_err;
    logic [15:0] exp_ir;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    req_cnt = 0; en_cnt = 0; err_cnt = 0;
    lat = v.lat; rd_word = v.data; xor_addr = 1'b0;
    if (v.exp_en != 0) sb_q.push_back('{addr: v.exp_addr, data: v.data});
    @(posedge clk); #1;
    fetch_go = 1'b1; pc_load = v.ld; pc_load_val = v.val;
    @(posedge clk); #1;
    fetch_go = 1'b0; pc_load = 1'b0;
    wait_idle("vec");
    chk("vec_addr", first_addr, v.exp_addr);
    chk("vec_req_cycles", req_cnt, v.exp_req);
    chk("vec_en_pulses", en_cnt, v.exp_en);
    chk("vec_err_pulses", err_cnt, v.exp_err);
    chk("vec_pc", pc, v.exp_pc);
    chk("vec_mem_addr", mem_addr, v.exp_pc);
    chk("vec_ir_d", ir_d, v.exp_ir);
  endtask

  initial begin
    // ld, val, lat, data, addr, pc, req, en, err, ir
    vecs[0] = '{1'b0, 16'h0000,  1, 16'hA5C3, 16'h0010, 16'h0011,  1, 1, 0, 16'hA5C3};
    vecs[1] = '{1'b0, 16'h0000,  4, 16'h1234, 16'h0011, 16'h0012,  4, 1, 0, 16'h1234};
    vecs[2] = '{1'b1, 16'h0200,  1, 16'hBEEF, 16'h0200, 16'h0201,  1, 1, 0, 16'hBEEF};
    vecs[3] = '{1'b1, 16'hFFFF,  2, 16'h0F0F, 16'hFFFF, 16'h0000,  2, 1, 0, 16'h0F0F};
    vecs[4] = '{1'b0, 16'h0000,  0, 16'hDEAD, 16'h0000, 16'h0000, 15, 0, 1, 16'h0F0F};
    vecs[5] = '{1'b0, 16'h0000, 15, 16'hCAFE, 16'h0000, 16'h0001, 15, 1, 0, 16'hCAFE};
    vecs[6] = '{1'b0, 16'h0000, 16, 16'hBAD0, 16'h0001, 16'h0001, 15, 0, 1, 16'hCAFE};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_mem_addr", mem_addr, RST_PC);
    chk("rst_outs", {mem_req, busy, en_ir, fetch_err}, 4'b0000);
    chk("rst_ir_d", ir_d, 16'h0000);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Plain pc_load in IDLE without a fetch.
    @(posedge clk); #1; pc_load = 1'b1; pc_load_val = 16'h0000;
    @(posedge clk); #1; pc_load = 1'b0;
    @(negedge clk);
    chk("load_only_pc", pc, 16'h0000);
    chk("load_only_busy", busy, 1'b0);

    // Back-to-back fetches with fetch_go held high.
    lat = 1; rd_word = 16'h7700; xor_addr = 1'b1; en_cnt = 0;
    en_cyc_q.delete();
    for (int a = 0; a < 3; a++) sb_q.push_back('{addr: 16'(a), data: 16'h7700 ^ 16'(a)});
    @(posedge clk); #1; fetch_go = 1'b1;
    for (int i = 0; i < 40 && en_cnt < 3; i++) @(negedge clk);
    fetch_go = 1'b0;
    wait_idle("b2b");
    chk("b2b_en_pulses", en_cnt, 3);
    chk("b2b_pc", pc, 16'h0003);
    if (en_cyc_q.size() == 3) begin
      chk("b2b_gap1", en_cyc_q[1] - en_cyc_q[0], 3);
      chk("b2b_gap2", en_cyc_q[2] - en_cyc_q[1], 3);
    end else begin
      checks++; failures++;
      $display("FAIL b2b_strobe_count actual=%0d required=3", en_cyc_q.size());
    end

    // pc_load while in REQ is ignored.
    lat = 3; rd_word = 16'h1111; xor_addr = 1'b0; en_cnt = 0;
    sb_q.push_back('{addr: 16'h0003, data: 16'h1111});
    @(posedge clk); #1; fetch_go = 1'b1;
    @(posedge clk); #1; fetch_go = 1'b0; pc_load = 1'b1; pc_load_val = 16'h1234;
    @(negedge clk);
    chk("req_load_pc_held", pc, 16'h0003);
    @(posedge clk); #1; pc_load = 1'b0;
    wait_idle("reqload");
    chk("req_load_pc_after", pc, 16'h0004);
    chk("req_load_en", en_cnt, 1);

    // Asynchronous reset in the middle of a request.
    lat = 0; en_cnt = 0;
    @(posedge clk); #1; fetch_go = 1'b1;
    @(posedge clk); #1; fetch_go = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_req_before_rst", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req_drop", mem_req, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_pc", pc, RST_PC);
    @(negedge clk); rst = 1'b1; stray_ack = 1'b1;
    repeat (4) @(negedge clk);
    stray_ack = 1'b0;
    chk("late_ack_no_en", en_cnt, 0);
    chk("late_ack_busy", busy, 1'b0);
    chk("late_ack_pc", pc, RST_PC);

    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
